// File: rtl/mem_pkg.sv
// Shared types and decode helpers for the memory-stage data-bus initiator.
// Opcode values follow the execute stage's aluop encoding.
package mem_pkg;

    localparam int ADEL_BIT_DEF = 4;
    localparam int ADES_BIT_DEF = 5;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_DONE    = 3'd3,
        S_DRAIN_A = 3'd4,
        S_DRAIN_D = 3'd5
    } mem_state_e;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic       sign_ext;
        logic [1:0] size;
    } op_dec_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_req_t;

    function automatic op_dec_t decode_op(input logic [7:0] op);
        op_dec_t d;
        d = '0;
        case (op)
            OP_LB:   begin d.is_load  = 1'b1; d.sign_ext = 1'b1; d.size = SIZE_B; end
            OP_LBU:  begin d.is_load  = 1'b1; d.size = SIZE_B; end
            OP_LH:   begin d.is_load  = 1'b1; d.sign_ext = 1'b1; d.size = SIZE_H; end
            OP_LHU:  begin d.is_load  = 1'b1; d.size = SIZE_H; end
            OP_LW:   begin d.is_load  = 1'b1; d.size = SIZE_W; end
            OP_SB:   begin d.is_store = 1'b1; d.size = SIZE_B; end
            OP_SH:   begin d.is_store = 1'b1; d.size = SIZE_H; end
            OP_SW:   begin d.is_store = 1'b1; d.size = SIZE_W; end
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SIZE_H) && addr_lo[0]) || ((size == SIZE_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication and strobes, load byte/half
// extraction with sign or zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] reg2,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wdata = reg2;
        wstrb = 4'h0;
        case (size)
            SIZE_B:  wdata = {4{reg2[7:0]}};
            SIZE_H:  wdata = {2{reg2[15:0]}};
            default: wdata = reg2;
        endcase
        if (is_store) begin
            case (size)
                SIZE_B:  wstrb = 4'b0001 << addr_lo;
                SIZE_H:  wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                default: wstrb = 4'hF;
            endcase
        end
    end

    always_comb begin
        byte_sel  = rdata[7:0];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (size)
            SIZE_B:  load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_H:  load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_data_access.sv
// Memory-stage initiator: issues loads/stores on the data bus, raises address
// errors, and stalls the pipeline until the access has completed.
module mem_data_access
    import mem_pkg::*;
#(
    parameter int ADEL_BIT = ADEL_BIT_DEF,
    parameter int ADES_BIT = ADES_BIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_except_type,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] result_o,
    output logic [31:0] except_type_o,
    output logic [31:0] badvaddr_o,
    output logic        stall_req
);

    // Bus handshake: a request is accepted in the cycle data_req && data_addr_ok;
    // its completion is the first later-or-same cycle with data_data_ok. Once
    // raised, data_req and every bus field stay stable until accepted.

    mem_state_e  state_q, state_d;
    op_dec_t     dec;
    bus_req_t    bus_new, bus_q, bus_out;
    logic [31:0] load_q;
    logic [31:0] lane_wdata, lane_load;
    logic [3:0]  lane_wstrb;
    logic [31:0] exc_add;
    logic        is_mem, misaligned, acc_valid;
    logic        req_c, stall_c, use_held, take_data, drive;

    assign dec        = decode_op(mem_aluop);
    assign is_mem     = dec.is_load | dec.is_store;
    assign misaligned = is_mem & is_misaligned(dec.size, mem_mem_addr[1:0]);
    assign acc_valid  = is_mem && (mem_except_type == 32'd0) && !misaligned && !flush;

    mem_lane_align u_lane (
        .size      (dec.size),
        .sign_ext  (dec.sign_ext),
        .is_store  (dec.is_store),
        .addr_lo   (mem_mem_addr[1:0]),
        .reg2      (mem_reg2),
        .rdata     (data_rdata),
        .wdata     (lane_wdata),
        .wstrb     (lane_wstrb),
        .load_data (lane_load)
    );

    always_comb begin
        bus_new       = '0;
        bus_new.wr    = dec.is_store;
        bus_new.size  = dec.size;
        bus_new.addr  = mem_mem_addr;
        bus_new.wdata = lane_wdata;
        bus_new.wstrb = lane_wstrb;
    end

    always_comb begin
        state_d   = state_q;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        use_held  = 1'b0;
        take_data = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc_valid) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    if (data_addr_ok && data_data_ok) begin
                        state_d   = S_DONE;
                        take_data = 1'b1;
                    end else if (data_addr_ok) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                req_c    = 1'b1;
                stall_c  = 1'b1;
                use_held = 1'b1;
                // A flush that coincides with acceptance must not re-raise the request.
                if (data_addr_ok) begin
                    if (flush) begin
                        state_d = data_data_ok ? S_IDLE : S_DRAIN_D;
                    end else if (data_data_ok) begin
                        state_d   = S_DONE;
                        take_data = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN_A;
                end
            end
            S_DATA: begin
                stall_c = 1'b1;
                if (data_data_ok) begin
                    state_d   = flush ? S_IDLE : S_DONE;
                    take_data = !flush;
                end else if (flush) begin
                    state_d = S_DRAIN_D;
                end
            end
            S_DONE: begin
                if (flush || en) state_d = S_IDLE;
            end
            S_DRAIN_A: begin
                req_c    = 1'b1;
                use_held = 1'b1;
                stall_c  = acc_valid;
                if (data_addr_ok) state_d = data_data_ok ? S_IDLE : S_DRAIN_D;
            end
            S_DRAIN_D: begin
                stall_c = acc_valid;
                if (data_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            load_q  <= 32'd0;
            bus_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take_data) load_q <= lane_load;
            if (state_q == S_IDLE && acc_valid) bus_q <= bus_new;
        end
    end

    always_comb begin
        exc_add           = 32'd0;
        exc_add[ADEL_BIT] = misaligned & dec.is_load;
        exc_add[ADES_BIT] = misaligned & dec.is_store;
    end

    // Outputs are gated by the asynchronous reset so they clear immediately.
    assign drive   = rst & req_c;
    assign bus_out = use_held ? bus_q : bus_new;

    assign data_req      = drive;
    assign data_wr       = drive & bus_out.wr;
    assign data_size     = drive ? bus_out.size  : 2'd0;
    assign data_addr     = drive ? bus_out.addr  : 32'd0;
    assign data_wdata    = drive ? bus_out.wdata : 32'd0;
    assign data_wstrb    = drive ? bus_out.wstrb : 4'd0;
    assign stall_req     = rst & stall_c;
    assign result_o      = !rst ? 32'd0 :
                           ((state_q == S_DONE) && dec.is_load) ? load_q : mem_wdata;
    assign except_type_o = rst ? (mem_except_type | exc_add) : 32'd0;
    assign badvaddr_o    = (rst && misaligned) ? mem_mem_addr : 32'd0;

endmodule

// File: tb/tb_mem_data_access.sv
// Directed bench for mem_data_access: a latency-programmable bus responder,
// a driver per operation, and a monitor that scores bus requests and results.
module tb_mem_data_access;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  mem_aluop = 8'h00;
    logic [31:0] mem_mem_addr = 32'd0;
    logic [31:0] mem_reg2 = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_except_type = 32'd0;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'd0;
    logic [31:0] result_o, except_type_o, badvaddr_o;
    logic        stall_req;

    always #5 clk = ~clk;

    mem_data_access dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .flush           (flush),
        .mem_aluop       (mem_aluop),
        .mem_mem_addr    (mem_mem_addr),
        .mem_reg2        (mem_reg2),
        .mem_wdata       (mem_wdata),
        .mem_except_type (mem_except_type),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_wstrb      (data_wstrb),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata),
        .result_o        (result_o),
        .except_type_o   (except_type_o),
        .badvaddr_o      (badvaddr_o),
        .stall_req       (stall_req)
    );

    int n_checks = 0;
    int n_pass = 0;
    int acc_cnt = 0;
    logic op_valid = 1'b0;
    logic [70:0] exp_bus_q[$];
    logic [95:0] exp_res_q[$];

    int bus_a_dly = 0;
    int bus_d_dly = 0;
    int a_cnt = 0;
    int d_rem = 0;
    logic [31:0] bus_rdata = 32'd0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [70:0] bus_w(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                                          input logic [31:0] wd, input logic [3:0] st);
        return {wr, sz, a, wd, st};
    endfunction

    function automatic logic [95:0] res_w(input logic [31:0] r, input logic [31:0] e, input logic [31:0] b);
        return {r, e, b};
    endfunction

    // Bus responder: accepts after bus_a_dly request cycles, completes bus_d_dly cycles later.
    always begin
        @(posedge clk);
        #2;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'hDEAD_DEAD;
        if (!rst) begin
            a_cnt = 0;
            d_rem = 0;
        end else if (d_rem > 0) begin
            d_rem--;
            if (d_rem == 0) begin
                data_data_ok = 1'b1;
                data_rdata   = bus_rdata;
            end
        end else if (data_req) begin
            if (a_cnt >= bus_a_dly) begin
                data_addr_ok = 1'b1;
                a_cnt = 0;
                if (bus_d_dly == 0) begin
                    data_data_ok = 1'b1;
                    data_rdata   = bus_rdata;
                end else begin
                    d_rem = bus_d_dly;
                end
            end else begin
                a_cnt++;
            end
        end
    end

    // Monitor: scores every accepted request and every consumed result.
    always @(negedge clk) begin
        if (rst && data_req && data_addr_ok) begin
            acc_cnt++;
            if (exp_bus_q.size() == 0) begin
                n_checks++;
                $display("FAIL bus_unexpected: got addr %h with no request expected", data_addr);
            end else begin
                check("bus_fields", 128'({data_wr, data_size, data_addr, data_wdata, data_wstrb}),
                      128'(exp_bus_q.pop_front()));
            end
        end
        if (rst && en && !stall_req && op_valid) begin
            if (exp_res_q.size() == 0) begin
                n_checks++;
                $display("FAIL result_unexpected: got result %h with none expected", result_o);
            end else begin
                check("result", 128'({result_o, except_type_o, badvaddr_o}), 128'(exp_res_q.pop_front()));
            end
        end
    end

    task automatic present_nop();
        en = 1'b0; flush = 1'b0; op_valid = 1'b0;
        mem_aluop = 8'h00; mem_mem_addr = 32'd0; mem_reg2 = 32'd0;
        mem_wdata = 32'd0; mem_except_type = 32'd0;
    endtask

    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] wdata, input logic [31:0] exc,
                          input int a_dly, input int d_dly, input logic [31:0] rdata,
                          input logic has_bus, input logic [70:0] exp_bus,
                          input logic [95:0] exp_res, input int exp_stall, input int en_hold);
        int stalls = 0;
        int acc0;
        logic unstable = 1'b0;
        logic timeout = 1'b1;
        @(posedge clk); #1;
        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
        mem_wdata = wdata; mem_except_type = exc;
        en = 1'b0; flush = 1'b0; op_valid = 1'b1;
        bus_a_dly = a_dly; bus_d_dly = d_dly; bus_rdata = rdata;
        if (has_bus) exp_bus_q.push_back(exp_bus);
        exp_res_q.push_back(exp_res);
        acc0 = acc_cnt;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!stall_req) begin
                timeout = 1'b0;
                break;
            end
            stalls++;
            if (data_req && ({data_wr, data_size, data_addr, data_wdata, data_wstrb} !== exp_bus))
                unstable = 1'b1;
            @(posedge clk); #1;
        end
        check("stall_timeout", 128'(timeout), 128'(0));
        check("stall_cycles", 128'(stalls), 128'(exp_stall));
        if (has_bus) check("req_stable", 128'(unstable), 128'(0));
        for (int h = 0; h < en_hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("done_hold", 128'({stall_req, data_req, result_o}), 128'({1'b0, 1'b0, exp_res[95:64]}));
        end
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        check("req_count", 128'(acc_cnt - acc0), 128'(has_bus ? 1 : 0));
        @(posedge clk); #1;
        present_nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        logic early, drained, timeout;

        // Reset with a valid-looking load presented: everything must read zero.
        mem_aluop = OP_LW; mem_mem_addr = 32'h0000_1000; mem_wdata = 32'h1234_5678;
        mem_except_type = 32'h0000_0040; en = 1'b1;
        #12;
        check("rst_bus", 128'({data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb}), 128'(0));
        check("rst_result", 128'({result_o, except_type_o, badvaddr_o}), 128'(0));
        check("rst_stall", 128'(stall_req), 128'(0));
        @(posedge clk); #1;
        present_nop();
        rst = 1'b1;

        run_op(OP_SB, 32'h0000_1003, 32'h0000_00AB, 32'h1111_0001, 32'd0, 0, 0, 32'd0,
               1'b1, bus_w(1'b1, 2'd0, 32'h0000_1003, 32'hABAB_ABAB, 4'b1000),
               res_w(32'h1111_0001, 32'd0, 32'd0), 1, 0);
        run_op(OP_LH, 32'h0000_2002, 32'd0, 32'h2222_0002, 32'd0, 2, 3, 32'h8001_7FFF,
               1'b1, bus_w(1'b0, 2'd1, 32'h0000_2002, 32'd0, 4'b0000),
               res_w(32'hFFFF_8001, 32'd0, 32'd0), 6, 0);
        run_op(OP_LW, 32'h0000_3001, 32'd0, 32'h3333_0003, 32'd0, 0, 0, 32'd0,
               1'b0, 71'd0, res_w(32'h3333_0003, 32'h0000_0010, 32'h0000_3001), 0, 0);
        run_op(OP_SH, 32'h0000_4006, 32'h1234_BEEF, 32'h4444_0004, 32'd0, 1, 1, 32'd0,
               1'b1, bus_w(1'b1, 2'd1, 32'h0000_4006, 32'hBEEF_BEEF, 4'b1100),
               res_w(32'h4444_0004, 32'd0, 32'd0), 3, 0);
        run_op(OP_SW, 32'h0000_5002, 32'h0BAD_F00D, 32'h5555_0005, 32'h0000_0001, 0, 0, 32'd0,
               1'b0, 71'd0, res_w(32'h5555_0005, 32'h0000_0021, 32'h0000_5002), 0, 0);
        run_op(OP_LBU, 32'h0000_6001, 32'd0, 32'h6666_0006, 32'd0, 0, 0, 32'h1122_83F0,
               1'b1, bus_w(1'b0, 2'd0, 32'h0000_6001, 32'd0, 4'b0000),
               res_w(32'h0000_0083, 32'd0, 32'd0), 1, 2);
        run_op(OP_LB, 32'h0000_7002, 32'd0, 32'h7777_0007, 32'd0, 0, 2, 32'h0080_0000,
               1'b1, bus_w(1'b0, 2'd0, 32'h0000_7002, 32'd0, 4'b0000),
               res_w(32'hFFFF_FF80, 32'd0, 32'd0), 3, 0);
        run_op(OP_LHU, 32'h0000_8000, 32'd0, 32'h8888_0008, 32'd0, 3, 0, 32'h1234_F00D,
               1'b1, bus_w(1'b0, 2'd1, 32'h0000_8000, 32'd0, 4'b0000),
               res_w(32'h0000_F00D, 32'd0, 32'd0), 4, 0);
        run_op(8'h00, 32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'd0, 0, 0, 32'd0,
               1'b0, 71'd0, res_w(32'hDEAD_BEEF, 32'd0, 32'd0), 0, 0);
        run_op(OP_SW, 32'h0000_C000, 32'h1357_9BDF, 32'hCCCC_000C, 32'h0000_0100, 0, 0, 32'd0,
               1'b0, 71'd0, res_w(32'hCCCC_000C, 32'h0000_0100, 32'd0), 0, 0);

        // Flush a load while it waits for data, then present a store behind it.
        @(posedge clk); #1;
        mem_aluop = OP_LW; mem_mem_addr = 32'h0000_9000; mem_reg2 = 32'd0;
        mem_wdata = 32'h9999_0009; mem_except_type = 32'd0; op_valid = 1'b1; en = 1'b0;
        bus_a_dly = 0; bus_d_dly = 5; bus_rdata = 32'h55AA_55AA;
        exp_bus_q.push_back(bus_w(1'b0, 2'd2, 32'h0000_9000, 32'd0, 4'b0000));
        @(negedge clk);
        check("flush_issue_stall", 128'(stall_req), 128'(1));
        @(posedge clk); #1;
        flush = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        check("flush_data_stall", 128'({stall_req, data_req}), 128'(2'b10));
        @(posedge clk); #1;
        flush = 1'b0; mem_aluop = OP_SW; mem_mem_addr = 32'h0000_A000;
        mem_reg2 = 32'hCAFE_F00D; mem_wdata = 32'h7777_0007; op_valid = 1'b1;
        bus_d_dly = 0; bus_rdata = 32'd0;
        exp_bus_q.push_back(bus_w(1'b1, 2'd2, 32'h0000_A000, 32'hCAFE_F00D, 4'hF));
        exp_res_q.push_back(res_w(32'h7777_0007, 32'd0, 32'd0));
        stalls = 0; early = 1'b0; drained = 1'b0; timeout = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall_req) begin
                timeout = 1'b0;
                break;
            end
            stalls++;
            if (data_req && !drained) early = 1'b1;
            if (data_data_ok) drained = 1'b1;
            @(posedge clk); #1;
        end
        check("drain_timeout", 128'(timeout), 128'(0));
        check("drain_early_req", 128'(early), 128'(0));
        check("drain_seen", 128'(drained), 128'(1));
        check("drain_stalls", 128'(stalls), 128'(5));
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        present_nop();

        // Asynchronous reset while a request waits for acceptance.
        @(posedge clk); #1;
        mem_aluop = OP_LW; mem_mem_addr = 32'h0000_B000; mem_wdata = 32'hBBBB_000B;
        bus_a_dly = 20; bus_d_dly = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("addr_wait", 128'({data_req, stall_req, data_addr}), 128'({1'b1, 1'b1, 32'h0000_B000}));
        #2;
        rst = 1'b0;
        #1;
        check("midrst_bus", 128'({data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb}), 128'(0));
        check("midrst_result", 128'({result_o, except_type_o, badvaddr_o, stall_req}), 128'(0));
        @(posedge clk); #1;
        present_nop();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 128'({data_req, stall_req}), 128'(0));

        run_op(OP_SW, 32'h0000_D004, 32'hCAFE_F00D, 32'hDDDD_000D, 32'd0, 0, 0, 32'd0,
               1'b1, bus_w(1'b1, 2'd2, 32'h0000_D004, 32'hCAFE_F00D, 4'hF),
               res_w(32'hDDDD_000D, 32'd0, 32'd0), 1, 0);

        repeat (2) @(posedge clk);
        check("queues_empty", 128'({exp_bus_q.size(), exp_res_q.size()}), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
